// File: rtl/flag_status_reg_pkg.sv
// Shared ALU definitions: opcodes, condition codes, holding-FSM states and the flag bundle.
package flag_status_reg_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,
    CC_NE = 4'd1,
    CC_CS = 4'd2,
    CC_CC = 4'd3,
    CC_MI = 4'd4,
    CC_PL = 4'd5,
    CC_VS = 4'd6,
    CC_VC = 4'd7,
    CC_HI = 4'd8,
    CC_LS = 4'd9,
    CC_GE = 4'd10,
    CC_LT = 4'd11,
    CC_GT = 4'd12,
    CC_LE = 4'd13,
    CC_AL = 4'd14,
    CC_NV = 4'd15
  } cond_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

  function automatic logic is_arith(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/flag_status_reg_if.sv
// Bundle of the ALU-beat handshake, flag consumer handshake and sticky-overflow signals.
interface flag_status_reg_if #(
  parameter int SIZE  = 4,
  parameter int CNT_W = 8
) ();

  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_select;
  logic [SIZE-1:0]  result;
  logic             flag_c;
  logic             flag_v;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       flags_q;
  logic [3:0]       cond_sel;
  logic             cond_true;
  logic             sticky_v;
  logic             clr_sticky;
  logic [CNT_W-1:0] ovf_count;

  modport master (
    output in_valid, alu_select, result, flag_c, flag_v, out_ready, cond_sel, clr_sticky,
    input  in_ready, out_valid, flags_q, cond_true, sticky_v, ovf_count
  );

  modport slave (
    input  in_valid, alu_select, result, flag_c, flag_v, out_ready, cond_sel, clr_sticky,
    output in_ready, out_valid, flags_q, cond_true, sticky_v, ovf_count
  );

endinterface

// File: rtl/flag_status_reg_cond_eval.sv
// Combinational condition-code evaluator over a held {N,Z,C,V} bundle.
module cond_eval
  import flag_status_reg_pkg::*;
(
  input  flags_t     flags,
  input  logic [3:0] cond_sel,
  output logic       cond_true
);

  always_comb begin
    cond_true = 1'b0;
    case (cond_e'(cond_sel))
      CC_EQ: cond_true = flags.z;
      CC_NE: cond_true = !flags.z;
      CC_CS: cond_true = flags.c;
      CC_CC: cond_true = !flags.c;
      CC_MI: cond_true = flags.n;
      CC_PL: cond_true = !flags.n;
      CC_VS: cond_true = flags.v;
      CC_VC: cond_true = !flags.v;
      CC_HI: cond_true = flags.c && !flags.z;
      CC_LS: cond_true = !flags.c || flags.z;
      CC_GE: cond_true = (flags.n == flags.v);
      CC_LT: cond_true = (flags.n != flags.v);
      CC_GT: cond_true = !flags.z && (flags.n == flags.v);
      CC_LE: cond_true = flags.z || (flags.n != flags.v);
      CC_AL: cond_true = 1'b1;
      CC_NV: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_status_reg.sv
// One-deep flag holding register with condition evaluation and a saturating sticky-overflow counter.
module flag_status_reg
  import flag_status_reg_pkg::*;
#(
  parameter int SIZE  = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  flag_status_reg_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_reg, state_next;
  flags_t           flags_reg;
  logic             sticky_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic   in_ready;
  logic   out_valid;
  logic   load;
  logic   arith;
  logic   count_beat;
  flags_t beat_flags;

  assign arith      = is_arith(bus.alu_select);
  assign beat_flags = '{n: bus.result[SIZE-1],
                        z: (bus.result == '0),
                        c: arith && bus.flag_c,
                        v: arith && bus.flag_v};
  assign count_beat = bus.in_valid && in_ready && arith && bus.flag_v;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b1;
    out_valid  = 1'b0;
    load       = 1'b0;
    case (state_reg)
      ST_EMPTY: begin
        if (bus.in_valid) begin
          load       = 1'b1;
          state_next = ST_FULL;
        end
      end
      ST_FULL: begin
        out_valid = 1'b1;
        in_ready  = bus.out_ready;
        if (bus.in_valid && bus.out_ready) begin
          load = 1'b1;
        end else if (bus.out_ready) begin
          state_next = ST_EMPTY;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_EMPTY;
      flags_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (load) begin
        flags_reg <= beat_flags;
      end
    end
  end

  // A counting beat takes priority over a simultaneous clear, restarting the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
    end else if (count_beat) begin
      sticky_reg <= 1'b1;
      if (bus.clr_sticky) begin
        cnt_reg <= CNT_ONE;
      end else if (cnt_reg != CNT_MAX) begin
        cnt_reg <= cnt_reg + CNT_ONE;
      end
    end else if (bus.clr_sticky) begin
      sticky_reg <= 1'b0;
      cnt_reg    <= '0;
    end
  end

  cond_eval u_cond_eval (
    .flags     (flags_reg),
    .cond_sel  (bus.cond_sel),
    .cond_true (bus.cond_true)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.flags_q   = flags_reg;
  assign bus.sticky_v  = sticky_reg;
  assign bus.ovf_count = cnt_reg;

endmodule

// File: tb/tb_flag_status_reg.sv
// Randomized scoreboard bench for flag_status_reg with a queue-based reference model.
module tb_flag_status_reg;

  localparam int SIZE  = 4;
  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  flag_status_reg_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

  flag_status_reg #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int         total = 0;
  int         bad   = 0;
  int         txn   = 0;
  logic [3:0] exp_q[$];
  logic [3:0] last_flags = 4'b0000;
  int         exp_cnt    = 0;
  bit         exp_sticky = 1'b0;
  bit         active     = 1'b0;

  // Condition table expressed directly on the four flag bits.
  function automatic bit cond_ref(input logic [3:0] f, input int sel);
    bit n, z, c, v;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    case (sel)
      0:  return z;
      1:  return !z;
      2:  return c;
      3:  return !c;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return c && !z;
      9:  return !c || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] flags_ref(input int sel, input logic [SIZE-1:0] res,
                                           input bit c, input bit v);
    bit arith;
    arith = (sel == 0) || (sel == 1);
    return {res[SIZE-1], (res == 0), arith & c, arith & v};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Drive one cycle of stimulus and advance the model by the outcome of the next edge.
  task automatic beat(input bit iv, input int sel, input int res, input bit c, input bit v,
                      input bit ordy, input bit clr, input int csel);
    bit exp_rdy, acc, counting;
    logic [3:0] ef;
    @(negedge clk);
    bus.in_valid   = iv;
    bus.alu_select = sel[3:0];
    bus.result     = res[SIZE-1:0];
    bus.flag_c     = c;
    bus.flag_v     = v;
    bus.out_ready  = ordy;
    bus.clr_sticky = clr;
    bus.cond_sel   = csel[3:0];
    #1;
    exp_rdy = (exp_q.size() == 0) || ordy;
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_rdy});
    acc      = iv && exp_rdy;
    counting = acc && (sel < 2) && v;
    ef       = flags_ref(sel, res[SIZE-1:0], c, v);
    @(posedge clk);
    #1;
    if (counting) begin
      exp_sticky = 1'b1;
      exp_cnt    = clr ? 1 : ((exp_cnt < CMAX) ? exp_cnt + 1 : CMAX);
    end else if (clr) begin
      exp_sticky = 1'b0;
      exp_cnt    = 0;
    end
    if (acc) exp_q.push_back(ef);
  endtask

  // Monitor: compares held output against the scoreboard, popping on each consumer handshake.
  initial begin
    logic [3:0] ef;
    forever begin
      @(negedge clk);
      #2;
      if (active) begin
        check("out_valid", {31'b0, bus.out_valid}, {31'b0, exp_q.size() != 0});
        ef = (exp_q.size() != 0) ? exp_q[0] : last_flags;
        check("flags_q", {28'b0, bus.flags_q}, {28'b0, ef});
        check("cond_true", {31'b0, bus.cond_true}, {31'b0, cond_ref(ef, int'(bus.cond_sel))});
        check("sticky_v", {31'b0, bus.sticky_v}, {31'b0, exp_sticky});
        check("ovf_count", 32'(bus.ovf_count), 32'(exp_cnt));
        if (bus.out_valid && bus.out_ready && exp_q.size() != 0) begin
          last_flags = exp_q.pop_front();
          txn++;
          $display("txn %0d: flags=%b sticky=%0d ovf=%0d", txn, last_flags, exp_sticky, exp_cnt);
        end
      end
    end
  end

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.alu_select = 4'd0;
    bus.result     = '0;
    bus.flag_c     = 1'b0;
    bus.flag_v     = 1'b0;
    bus.out_ready  = 1'b0;
    bus.clr_sticky = 1'b0;
    bus.cond_sel   = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_flags_q", {28'b0, bus.flags_q}, 32'd0);
    check("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_ovf_count", 32'(bus.ovf_count), 32'd0);
    @(negedge clk);
    rst    = 1'b0;
    active = 1'b1;

    // Directed: overflowing add held, blocked producer, replacement by a logic op.
    beat(1, 0, 4'b1000, 0, 1, 0, 0, 11);
    beat(1, 2, 0, 1, 1, 0, 0, 11);
    beat(1, 2, 0, 1, 1, 0, 0, 6);
    beat(1, 2, 0, 1, 1, 0, 0, 6);
    beat(1, 2, 0, 1, 1, 1, 0, 0);
    beat(0, 0, 0, 0, 0, 0, 0, 0);
    beat(0, 0, 0, 0, 0, 1, 0, 2);
    // Saturation, clear alone, then clear racing a counting beat.
    repeat (4) beat(1, 1, 5, 0, 1, 1, 0, 10);
    beat(0, 0, 0, 0, 0, 1, 1, 7);
    repeat (3) beat(1, 0, 3, 1, 1, 1, 0, 12);
    beat(1, 0, 9, 0, 1, 1, 1, 13);
    beat(0, 0, 0, 0, 0, 1, 0, 14);

    repeat (500) begin
      beat(($urandom % 4) != 0,
           (($urandom % 4) == 0) ? int'($urandom % 16) : int'($urandom % 2),
           int'($urandom % 16), $urandom % 2, $urandom % 2,
           $urandom % 2, ($urandom % 12) == 0, int'($urandom % 16));
    end

    // Asynchronous reset between edges while FULL.
    beat(1, 0, 4'b1111, 1, 1, 0, 0, 0);
    beat(1, 1, 4'b0110, 1, 1, 0, 0, 0);
    active = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("arst_flags_q", {28'b0, bus.flags_q}, 32'd0);
    check("arst_ovf_count", 32'(bus.ovf_count), 32'd0);
    check("arst_sticky_v", {31'b0, bus.sticky_v}, 32'd0);
    check("arst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    exp_q.delete();
    last_flags = 4'b0000;
    exp_cnt    = 0;
    exp_sticky = 1'b0;
    #1 rst = 1'b0;
    active = 1'b1;

    repeat (150) begin
      beat(($urandom % 3) != 0, int'($urandom % 4), int'($urandom % 16),
           $urandom % 2, $urandom % 2, $urandom % 2, ($urandom % 10) == 0,
           int'($urandom % 16));
    end
    beat(0, 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
